// File: rtl/tx_quad_upmixer_sd.sv
// Transmit quadrature upmixer: holds baseband I/Q for OSR clocks, mixes
// with NCO (I*cos - Q*sin), saturates, and drives a 1st-order sigma-delta.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   tx_en             : transmit enable
//   sin_in, cos_in    : signed NCO sine/cosine (WIDTH)
//   i_in, q_in        : signed baseband sample (WIDTH)
//   iq_valid/iq_ready : sample handshake, ready pulses every OSR clocks
//   underrun          : sticky, ready seen without valid
//   RFOut             : 1-bit RF stream, 0 = +FS, 1 = -FS
module tx_quad_upmixer_sd #(
  parameter int WIDTH = 12,
  parameter int OSR   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] sin_in,
  input  logic [WIDTH-1:0] cos_in,
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             iq_valid,
  output logic             iq_ready,
  output logic             underrun,
  output logic             RFOut
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int AW = WIDTH + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
  localparam logic signed [PW:0] MAXV =
    (PW+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PW:0] MINV = -MAXV;
  localparam logic signed [AW-1:0] FS =
    AW'(2 ** (WIDTH - 1));
  localparam logic signed [AW-1:0] FSN = -FS;

  logic [CW-1:0]           r_cnt;
  logic signed [WIDTH-1:0] r_i_hold;
  logic signed [WIDTH-1:0] r_q_hold;
  logic signed [PW-1:0]    r_pc;
  logic signed [PW-1:0]    r_ps;
  logic signed [WIDTH-1:0] r_mix;
  logic signed [AW-1:0]    r_acc;
  logic                    r_und;
  logic                    r_rf;

  logic                    w_accept;
  logic                    w_miss;
  logic signed [PW:0]      w_d;
  logic signed [PW:0]      w_m;
  logic signed [WIDTH-1:0] w_sat;
  logic                    w_y;
  logic signed [AW-1:0]    w_acc_nxt;

  assign iq_ready = tx_en & (r_cnt == '0);
  assign underrun = r_und;
  assign RFOut    = r_rf;

  assign w_accept = iq_ready & iq_valid;
  assign w_miss   = iq_ready & ~iq_valid;

  // Difference keeps one guard bit; floor shift back to sample scale.
  assign w_d = (PW+1)'(r_pc) - (PW+1)'(r_ps);
  assign w_m = w_d >>> WIDTH;

  // Symmetric clamp: only the most negative code is ever reached.
  always_comb begin
    w_sat = WIDTH'(w_m);
    if (w_m > MAXV)
      w_sat = WIDTH'(MAXV);
    else if (w_m < MINV)
      w_sat = WIDTH'(MINV);
  end

  assign w_y = ~r_acc[AW-1];
  assign w_acc_nxt = r_acc + AW'(r_mix)
                   - (w_y ? FS : FSN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!tx_en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_hold <= '0;
      r_q_hold <= '0;
      r_und    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_i_hold <= $signed(i_in);
        r_q_hold <= $signed(q_in);
      end
      if (w_miss)
        r_und <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_ps  <= '0;
      r_mix <= '0;
    end else begin
      r_pc  <= r_i_hold * $signed(cos_in);
      r_ps  <= r_q_hold * $signed(sin_in);
      r_mix <= w_sat;
    end
  end

  // Modulator restarts from zero whenever transmit is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_rf  <= 1'b1;
    end else if (!tx_en) begin
      r_acc <= '0;
      r_rf  <= 1'b1;
    end else begin
      r_acc <= w_acc_nxt;
      r_rf  <= ~w_y;
    end
  end

endmodule

// File: tb/tb_tx_quad_upmixer_sd.sv
// Bench for tx_quad_upmixer_sd (WIDTH=12, OSR=4) with an
// arithmetic reference model of handshake, mixer and modulator.
module tb_tx_quad_upmixer_sd;

  localparam int W   = 12;
  localparam int OSR = 4;
  localparam longint FS  = 2048;
  localparam longint LIM = 2047;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_en = 1'b0;
  logic [W-1:0] sin_in = '0;
  logic [W-1:0] cos_in = '0;
  logic [W-1:0] i_in = '0;
  logic [W-1:0] q_in = '0;
  logic         iq_valid = 1'b0;
  logic         iq_ready;
  logic         underrun;
  logic         RFOut;

  int checks = 0;
  int errors = 0;

  int     m_cnt = 0;
  longint m_ih = 0, m_qh = 0;
  longint m_e1 = 0, m_mix = 0;
  longint m_acc = 0;
  bit     m_rf = 1'b1;
  bit     m_und = 1'b0;

  tx_quad_upmixer_sd #(.WIDTH(W), .OSR(OSR)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .sin_in(sin_in), .cos_in(cos_in),
    .i_in(i_in), .q_in(q_in),
    .iq_valid(iq_valid), .iq_ready(iq_ready),
    .underrun(underrun), .RFOut(RFOut)
  );

  always #5 clk = ~clk;

  function automatic longint sx(logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint mixval(longint ih, longint qh,
                                    longint c, longint s);
    longint d, m;
    d = ih * c - qh * s;
    m = d >>> W;
    if (m > LIM) m = LIM;
    if (m < -LIM) m = -LIM;
    return m;
  endfunction

  function automatic bit m_rdy();
    return tx_en && (m_cnt == 0);
  endfunction

  task automatic tick();
    longint ne1;
    bit rdy, y;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_ih = 0; m_qh = 0;
      m_e1 = 0; m_mix = 0; m_acc = 0;
      m_rf = 1'b1; m_und = 1'b0;
    end else begin
      rdy = m_rdy();
      ne1 = mixval(m_ih, m_qh, sx(cos_in), sx(sin_in));
      if (tx_en) begin
        y = (m_acc >= 0);
        m_acc = m_acc + m_mix - (y ? FS : -FS);
        m_rf = !y;
      end else begin
        m_acc = 0;
        m_rf = 1'b1;
      end
      m_mix = m_e1;
      m_e1 = ne1;
      if (rdy && iq_valid) begin
        m_ih = sx(i_in);
        m_qh = sx(q_in);
      end
      if (rdy && !iq_valid) m_und = 1'b1;
      m_cnt = tx_en ? (m_cnt + 1) % OSR : 0;
    end
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    tx_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      i_in = W'($urandom); q_in = W'($urandom);
      sin_in = W'($urandom); cos_in = W'($urandom);
      iq_valid = (k % 8) != 4;
      tick();
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (RFOut !== 1'b1 || iq_ready !== 1'b1 ||
          underrun !== 1'b0 || dut.r_acc !== '0) begin
        errors++;
        $display("FAIL reset: rf=%b rdy=%b und=%b acc=%0d exp 1 1 0 0",
                 RFOut, iq_ready, underrun, $signed(dut.r_acc));
      end
    end
    rst = 1'b0;
    v = W'($urandom);
    i_in = v; iq_valid = 1'b1;
    tick();
    checks++;
    if (dut.r_i_hold !== v) begin
      errors++;
      $display("FAIL reset_accept: got %h expected %h",
               dut.r_i_hold, v);
    end
  endtask

  task automatic test_zero();
    do_reset(2);
    tx_en = 1'b1; iq_valid = 1'b1;
    i_in = '0; q_in = '0;
    for (int k = 0; k < 40; k++) begin
      sin_in = W'($urandom); cos_in = W'($urandom);
      tick();
      checks++;
      if (RFOut !== 1'(k % 2) ||
          iq_ready !== 1'((k + 1) % OSR == 0)) begin
        errors++;
        $display("FAIL zero k=%0d: rf=%b rdy=%b expected %b %b",
                 k, RFOut, iq_ready, 1'(k % 2),
                 1'((k + 1) % OSR == 0));
      end
    end
  endtask

  task automatic run_tone(string nm, logic [W-1:0] iv,
                          logic [W-1:0] qv, logic [W-1:0] cv,
                          logic [W-1:0] sv, longint emix,
                          int lo, int hi);
    int zc, mz;
    do_reset(2);
    tx_en = 1'b1; iq_valid = 1'b1;
    i_in = iv; q_in = qv; cos_in = cv; sin_in = sv;
    repeat (8) tick();
    checks++;
    if (longint'(dut.r_mix) !== emix) begin
      errors++;
      $display("FAIL %s_mix: got %0d expected %0d",
               nm, dut.r_mix, emix);
    end
    zc = 0; mz = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      if (RFOut == 1'b0) zc++;
      if (!m_rf) mz++;
    end
    checks++;
    if (zc < lo || zc > hi || zc != mz) begin
      errors++;
      $display("FAIL %s_density: got %0d expected %0d (range %0d..%0d)",
               nm, zc, mz, lo, hi);
    end
  endtask

  task automatic test_underrun();
    logic [W-1:0] s [6];
    for (int k = 0; k < 6; k++) s[k] = W'($urandom);
    do_reset(2);
    tx_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_in = s[c / OSR + 1];
      q_in = ~s[c / OSR + 1];
      iq_valid = (c != 2 * OSR);
      tick();
      if (c % OSR == 0) begin
        checks++;
        if (c / OSR == 2) begin
          if (underrun !== 1'b1 || dut.r_i_hold !== s[2]) begin
            errors++;
            $display("FAIL underrun_set: und=%b hold=%h expected 1 %h",
                     underrun, dut.r_i_hold, s[2]);
          end
        end else if (dut.r_i_hold !== s[c / OSR + 1] ||
                     underrun !== 1'(c / OSR > 2)) begin
          errors++;
          $display("FAIL underrun_accept c=%0d: hold=%h und=%b expected %h %b",
                   c, dut.r_i_hold, underrun, s[c / OSR + 1],
                   1'(c / OSR > 2));
        end
      end
    end
  endtask

  task automatic test_toggle();
    do_reset(2);
    tx_en = 1'b1; iq_valid = 1'b1;
    i_in = '0; q_in = '0;
    repeat (6) tick();
    tx_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (iq_ready !== 1'b0 || RFOut !== 1'b1) begin
        errors++;
        $display("FAIL toggle_off k=%0d: rdy=%b rf=%b expected 0 1",
                 k, iq_ready, RFOut);
      end
    end
    tx_en = 1'b1;
    #1;
    checks++;
    if (iq_ready !== 1'b1) begin
      errors++;
      $display("FAIL toggle_ready: got %b expected 1", iq_ready);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (RFOut !== 1'(k % 2)) begin
        errors++;
        $display("FAIL toggle_restart k=%0d: got %b expected %b",
                 k, RFOut, 1'(k % 2));
      end
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 31) == 0) tx_en = ~tx_en;
      if (k < 100) tx_en = 1'b1;
      i_in = W'($urandom); q_in = W'($urandom);
      sin_in = W'($urandom); cos_in = W'($urandom);
      iq_valid = ($urandom_range(0, 7) != 0);
      tick();
      checks++;
      if (RFOut !== m_rf || iq_ready !== m_rdy() ||
          underrun !== m_und || longint'(dut.r_mix) !== m_mix) begin
        errors++;
        $display("FAIL random k=%0d: rf=%b rdy=%b und=%b mix=%0d expected %b %b %b %0d",
                 k, RFOut, iq_ready, underrun, dut.r_mix,
                 m_rf, m_rdy(), m_und, m_mix);
      end
    end
  endtask

  initial begin
    do_reset(3);
    checks++;
    if (RFOut !== 1'b1 || underrun !== 1'b0 || iq_ready !== 1'b0) begin
      errors++;
      $display("FAIL initial_reset: rf=%b und=%b rdy=%b expected 1 0 0",
               RFOut, underrun, iq_ready);
    end
    test_reset();
    test_zero();
    run_tone("dc", 12'd2047, 12'd0, 12'd2047, 12'd0,
             1023, 3070, 3072);
    run_tone("sat", 12'h800, 12'h800, 12'd2047, 12'h800,
             -2047, 0, 2);
    test_underrun();
    test_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
